// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
// Lanes are packed [lane][bits]; lane i of a request addresses pc + 4*i.
interface fetch_queue_unit_if #(
  parameter int FETCH_W     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                                  imem_ren;
  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]    imem_addr;
  logic                                  imem_valid;
  logic [FETCH_W-1:0][INSTR_WIDTH-1:0]   imem_rdata;
  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]    imem_pc;

  modport master (
    output imem_ren, imem_addr,
    input  imem_valid, imem_rdata, imem_pc
  );

  modport slave (
    input  imem_ren, imem_addr,
    output imem_valid, imem_rdata, imem_pc
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// N-wide fetch unit: credit-limited sequential group requests, QDEPTH-group queue, redirect-safe drop of stale responses.
// Optional feature: define FETCH_PC_CHECK_EN to check echoed PCs and raise a sticky fetch_err.
package core_pkg;
  localparam int XLEN = 32;
endpackage

module fetch_queue_unit
  import core_pkg::*;
#(
  parameter int                     FETCH_W         = 2,
  parameter int                     ADDR_WIDTH      = XLEN,
  parameter int                     INSTR_WIDTH     = XLEN,
  parameter int                     QDEPTH          = 4,
  parameter int                     MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch_en,
  input  logic                                 stall,
  input  logic                                 redirect_en,
  input  logic [ADDR_WIDTH-1:0]                redirect_pc,
  fetch_queue_unit_if.master                   mem,
  output logic [FETCH_W-1:0]                   if_valid,
  output logic [FETCH_W-1:0][ADDR_WIDTH-1:0]   if_pc,
  output logic [FETCH_W-1:0][INSTR_WIDTH-1:0]  if_instr,
  output logic                                 fetch_err
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4 * FETCH_W);

  logic [ADDR_WIDTH-1:0] pc;
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [OUT_W-1:0]      inflight;
  logic [OUT_W-1:0]      drop_cnt;

  logic [FETCH_W-1:0][ADDR_WIDTH-1:0]  q_pc    [QDEPTH];
  logic [FETCH_W-1:0][INSTR_WIDTH-1:0] q_instr [QDEPTH];

  logic [SUM_W-1:0] credit_used;
  logic             req, resp, pc_bad, enq, deq, has_head;

  // Every in-flight request already owns a queue slot, so responses can never be refused.
  assign credit_used = SUM_W'(count) + SUM_W'(inflight);

  // NOTE: combinational blocks assign every output on every path (no else-less ifs), so no latch is inferred.
  always_comb begin
    req      = reset & fetch_en & ~redirect_en
             & (inflight < OUT_W'(MAX_OUTSTANDING))
             & (credit_used < SUM_W'(QDEPTH));
    // A response with nothing outstanding is a leftover from before reset.
    resp     = mem.imem_valid & (inflight != '0);
    enq      = resp & ~redirect_en & (drop_cnt == '0) & ~pc_bad;
    has_head = (count != '0);
    deq      = has_head & ~stall & ~redirect_en;
  end

  assign mem.imem_ren = req;

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      mem.imem_addr[i] = pc + ADDR_WIDTH'(4 * i);
    end
  end

  always_comb begin
    if_valid = {FETCH_W{has_head}};
    if_pc    = has_head ? q_pc[head]    : '0;
    if_instr = has_head ? q_instr[head] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + OUT_W'(req) - OUT_W'(resp);
      if (redirect_en) begin
        pc       <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        // Everything still outstanding after this edge belongs to the old stream.
        drop_cnt <= inflight - OUT_W'(resp);
      end else begin
        if (req)                      pc       <= pc + PC_STEP;
        if (resp && drop_cnt != '0)   drop_cnt <= drop_cnt - OUT_W'(1);
        if (enq)                      tail     <= tail + PTR_W'(1);
        if (deq)                      head     <= head + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // NOTE: queue storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]    <= mem.imem_pc;
      q_instr[tail] <= mem.imem_rdata;
    end
  end

`ifdef FETCH_PC_CHECK_EN
  logic [ADDR_WIDTH-1:0] exp_pc;
  logic                  err_q;

  assign pc_bad    = (mem.imem_pc[0] != exp_pc);
  assign fetch_err = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_pc <= RESET_PC;
      err_q  <= 1'b0;
    end else begin
      if (redirect_en)  exp_pc <= redirect_pc;
      else if (enq)     exp_pc <= exp_pc + PC_STEP;
      if (resp && !redirect_en && drop_cnt == '0 && pc_bad) err_q <= 1'b1;
    end
  end
`else
  assign pc_bad    = 1'b0;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: random stimulus, in-order variable-latency imem model, stream-level reference.
// A second FETCH_W=4 instance covers the wide configuration.
module tb_fetch_queue_unit;
  localparam int FW = 2, AW = 32, IW = 32, QD = 4, MO = 2;

  typedef logic [FW-1:0][AW-1:0] pcv_t;
  typedef logic [FW-1:0][IW-1:0] inv_t;
  typedef logic [3:0][31:0]      v4_t;
  typedef struct { pcv_t pc; inv_t instr; }          grp_t;
  typedef struct { pcv_t addr; int epoch; int due; } req_t;
  typedef struct { v4_t addr; int due; }             req4_t;

  logic clk, reset, fetch_en, stall, redirect_en, fetch_err;
  logic [AW-1:0] redirect_pc;
  logic [FW-1:0] if_valid;
  pcv_t          if_pc;
  inv_t          if_instr;

  logic fetch_en4, fetch_err4;
  logic [3:0] if_valid4;
  v4_t        if_pc4, if_instr4;

  fetch_queue_unit_if #(.FETCH_W(FW), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) m ();
  fetch_queue_unit_if #(.FETCH_W(4),  .ADDR_WIDTH(32), .INSTR_WIDTH(32)) m4 ();

  fetch_queue_unit #(.FETCH_W(FW), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .QDEPTH(QD),
                     .MAX_OUTSTANDING(MO), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .mem(m),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fetch_err(fetch_err));

  fetch_queue_unit #(.FETCH_W(4), .ADDR_WIDTH(32), .INSTR_WIDTH(32), .QDEPTH(4),
                     .MAX_OUTSTANDING(3), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en4), .stall(1'b0),
    .redirect_en(1'b0), .redirect_pc(32'h0), .mem(m4),
    .if_valid(if_valid4), .if_pc(if_pc4), .if_instr(if_instr4), .fetch_err(fetch_err4));

  int n_checks = 0, n_errs = 0;
  int cyc = 0, epoch = 0, lat = 2, first_req = -1, first_vld = -1;
  bit chk_en = 1, rand_lat = 0, corrupt = 0, corrupt_seen = 0, resp_on = 0, resp4_on = 0, got4 = 0;
  logic [AW-1:0] model_pc = '0;
  grp_t  sb[$];
  req_t  mem_q[$];
  pcv_t  req_log[$];
  grp_t  out_log[$];
  req4_t mem4_q[$];
  v4_t   req4_log[$];
  logic [3:0] first4_valid;
  v4_t        first4_pc, first4_instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]} + 32'd1;
    return 32'h11111111 * w;
  endfunction

  // Monitor: request-side credit model plus stream scoreboard on the decode side.
  always @(negedge clk) begin
    int fresh, credits;
    bit exp_ren;
    grp_t g;
    if (!reset) begin
      sb.delete(); req_log.delete(); out_log.delete();
      model_pc = '0; epoch++; first_req = -1; first_vld = -1;
    end else begin
      fresh = 0;
      foreach (mem_q[k]) if (mem_q[k].epoch == epoch) fresh++;
      credits = sb.size() - fresh + mem_q.size();
      exp_ren = fetch_en && !redirect_en && (mem_q.size() < MO) && (credits < QD);
      if (chk_en) check("imem_ren", m.imem_ren, exp_ren);
      if (m.imem_ren) begin
        for (int i = 0; i < FW; i++) begin
          g.pc[i]    = model_pc + 32'(4 * i);
          g.instr[i] = instr_of(g.pc[i]);
        end
        if (chk_en) check("imem_addr", m.imem_addr, g.pc);
        sb.push_back(g);
        mem_q.push_back('{m.imem_addr, epoch, cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
        req_log.push_back(m.imem_addr);
        if (first_req < 0) first_req = cyc;
        model_pc = model_pc + 32'(4 * FW);
      end
      if (if_valid != '0) begin
        if (first_vld < 0) first_vld = cyc;
        check("if_valid_lanes", if_valid, {FW{1'b1}});
        if (!stall && !redirect_en) begin
          out_log.push_back('{if_pc, if_instr});
          if (sb.size() == 0) begin
            if (chk_en) begin
              n_checks++; n_errs++;
              $display("FAIL spurious_group actual_pc=%0h required=none", if_pc);
            end
          end else begin
            g = sb.pop_front();
            if (chk_en) begin
              check("if_pc", if_pc, g.pc);
              check("if_instr", if_instr, g.instr);
            end
          end
        end
      end
      if (redirect_en) begin
        sb.delete(); model_pc = redirect_pc; epoch++;
      end
    end
  end

  // In-order imem: presents the oldest request once its latency has elapsed.
  always @(posedge clk) begin
    pcv_t p;
    inv_t d;
    #1;
    if (resp_on) void'(mem_q.pop_front());
    resp_on = 0;
    p = '0; d = '0;
    if (!reset) mem_q.delete();
    else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp_on = 1;
      p = mem_q[0].addr;
      for (int i = 0; i < FW; i++) d[i] = instr_of(p[i]);
      if (corrupt && p[0] == 32'h8) begin
        p[0] = 32'h40; corrupt_seen = 1;
      end
    end
    m.imem_valid = resp_on; m.imem_pc = p; m.imem_rdata = d;
  end

  // Wide instance: request log, credit bound, and a fixed latency-2 memory.
  always @(negedge clk) begin
    if (!reset) begin
      req4_log.delete(); got4 = 0;
    end else begin
      if (m4.imem_ren) begin
        check("w4_outstanding", mem4_q.size() < 3, 1'b1);
        req4_log.push_back(m4.imem_addr);
        mem4_q.push_back('{m4.imem_addr, cyc + 2});
      end
      if (if_valid4 != '0 && !got4) begin
        got4 = 1; first4_valid = if_valid4; first4_pc = if_pc4; first4_instr = if_instr4;
      end
    end
  end

  always @(posedge clk) begin
    v4_t p, d;
    #1;
    if (resp4_on) void'(mem4_q.pop_front());
    resp4_on = 0; p = '0; d = '0;
    if (!reset) mem4_q.delete();
    else if (mem4_q.size() > 0 && mem4_q[0].due <= cyc) begin
      resp4_on = 1; p = mem4_q[0].addr;
      for (int i = 0; i < 4; i++) d[i] = instr_of(p[i]);
    end
    m4.imem_valid = resp4_on; m4.imem_pc = p; m4.imem_rdata = d;
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    pcv_t e;
    inv_t ei;
    v4_t  e4;
    int   n, bad;
    reset = 0; fetch_en = 0; stall = 0; redirect_en = 0; redirect_pc = '0; fetch_en4 = 0;

    // Reset sequence
    cycle(); cycle();
    check("rst_imem_ren", m.imem_ren, 1'b0);
    check("rst_if_valid", if_valid, '0);
    check("rst_if_pc", if_pc, '0);
    check("rst_if_instr", if_instr, '0);
    check("rst_fetch_err", fetch_err, 1'b0);
    reset = 1; fetch_en = 1;

    // Stall for one cycle while group 0x08 is at the head
    n = 0;
    while (!(if_valid[0] && if_pc[0] == 32'h8) && n < 40) begin cycle(); n++; end
    check("wait_grp08", if_valid[0] && if_pc[0] == 32'h8, 1'b1);
    stall = 1;
    cycle();
    stall = 0;
    check("stall_hold_pc", if_pc[0], 32'h8);
    check("stall_hold_valid", if_valid, 2'b11);
    cycle();
    n = 0;
    while (!if_valid[0] && n < 40) begin cycle(); n++; end
    check("after_stall_pc", if_pc[0], 32'h10);

    check("first_reqs_seen", req_log.size() >= 2, 1'b1);
    e[0] = 32'h0; e[1] = 32'h4;
    check("first_req_addr", req_log[0], e);
    e[0] = 32'h8; e[1] = 32'hC;
    check("second_req_addr", req_log[1], e);
    e[0] = 32'h0; e[1] = 32'h4;
    ei[0] = 32'h11111111; ei[1] = 32'h22222222;
    check("first_out_pc", out_log[0].pc, e);
    check("first_out_instr", out_log[0].instr, ei);
    check("first_out_latency", first_vld - first_req, 3);

    // Redirect with two stale requests in flight
    lat = 3;
    n = 0;
    while (!(mem_q.size() == 2 && !m.imem_valid) && n < 40) begin cycle(); n++; end
    check("wait_two_inflight", mem_q.size() == 2 && !m.imem_valid, 1'b1);
    redirect_en = 1; redirect_pc = 32'h8;
    #1;
    check("redirect_ren", m.imem_ren, 1'b0);
    cycle();
    redirect_en = 0;
    check("redirect_drop_cnt", dut.drop_cnt, 2);
    check("redirect_if_valid", if_valid, '0);
    lat = 2;
    n = 0;
    while (!if_valid[0] && n < 40) begin cycle(); n++; end
    e[0] = 32'h8; e[1] = 32'hC;
    check("redirect_next_pc", if_pc, e);

    // Mid-operation reset, then back-pressure with the queue filling up
    reset = 0;
    cycle(); cycle();
    check("rst2_if_valid", if_valid, '0);
    check("rst2_count", dut.count, 0);
    reset = 1; fetch_en = 1; stall = 1;
    repeat (10) cycle();
    check("bp_count", dut.count, 4);
    check("bp_imem_ren", m.imem_ren, 1'b0);
    check("bp_inflight", mem_q.size(), 0);
    check("bp_head_pc", if_pc[0], 32'h0);
    stall = 0; fetch_en = 0;
    n = 0;
    while (out_log.size() < 4 && n < 40) begin cycle(); n++; end
    check("bp_drained", out_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("bp_order%0d", i), out_log[i].pc[0], 32'(8 * i));

    // Randomized traffic with redirects, variable latency and PC wrap
    rand_lat = 1;
    for (int t = 0; t < 1500; t++) begin
      cycle();
      fetch_en    = ($urandom_range(0, 7) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = $urandom & 32'h0000_FFFC;
        2:       redirect_pc = $urandom;
        default: redirect_pc = 32'h100;
      endcase
    end
    cycle();
    fetch_en = 0; stall = 0; redirect_en = 0;
    n = 0;
    while ((sb.size() != 0 || mem_q.size() != 0) && n < 100) begin cycle(); n++; end
    check("drain_sb_empty", sb.size(), 0);
    cycle();
    check("drain_if_valid", if_valid, '0);
    rand_lat = 0; lat = 2;

`ifdef FETCH_PC_CHECK_EN
    // Echoed PC 0x40 where 0x08 is expected
    reset = 0; chk_en = 0;
    cycle(); cycle();
    corrupt = 1; reset = 1; fetch_en = 1;
    n = 0;
    while (!corrupt_seen && n < 20) begin cycle(); n++; end
    check("pc_bad_seen", corrupt_seen, 1'b1);
    check("pc_err_before", fetch_err, 1'b0);
    cycle();
    check("pc_err_set", fetch_err, 1'b1);
    repeat (10) cycle();
    check("pc_err_sticky", fetch_err, 1'b1);
    bad = 0;
    foreach (out_log[k]) if (out_log[k].pc[0] != 32'h0) bad++;
    check("pc_bad_dropped", bad, 0);
    check("pc_good_delivered", out_log.size(), 1);
    fetch_en = 0; corrupt = 0; reset = 0;
    cycle();
    check("pc_err_cleared", fetch_err, 1'b0);
    reset = 1; chk_en = 1;
    cycle();
`endif

    // Wide configuration: FETCH_W=4, MAX_OUTSTANDING=3
    fetch_en4 = 1;
    repeat (12) cycle();
    fetch_en4 = 0;
    for (int i = 0; i < 4; i++) e4[i] = 32'(4 * i);
    check("w4_first_addr", req4_log[0], e4);
    for (int i = 0; i < 4; i++) e4[i] = 32'(16 + 4 * i);
    check("w4_second_addr", req4_log[1], e4);
    check("w4_got_output", got4, 1'b1);
    check("w4_if_valid", first4_valid, 4'hF);
    for (int i = 0; i < 4; i++) e4[i] = 32'(4 * i);
    check("w4_first_pc", first4_pc, e4);
    for (int i = 0; i < 4; i++) e4[i] = 32'h11111111 * 32'(i + 1);
    check("w4_first_instr", first4_instr, e4);
    check("w4_fetch_err", fetch_err4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised N-wide instruction fetch unit with an internal fetch queue and redirect-safe handling of in-flight memory responses. It generates grouped sequential PC requests to a tagged, in-order, fixed-or-variable-latency instruction memory. Returned groups are buffered in a QDEPTH-entry FIFO, and one group per cycle is presented to decode. It replaces the fixed two-slot fetch stage between the PC/branch-redirect logic and decode.

## Interface
- FETCH_W, 2: instructions per group (≥1).
- ADDR_WIDTH, core_pkg::XLEN: PC width.
- INSTR_WIDTH, core_pkg::XLEN: instruction width.
- QDEPTH, 4: fetch-queue entries, in groups (power of 2, ≥2).
- MAX_OUTSTANDING, 2: maximum imem requests in flight (≥1).
- RESET_PC, 0: PC loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_en  in  1  permits new imem requests.
- stall  in  1  decode not accepting; holds the output group.
- redirect_en  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- imem_ren  out  1  request valid.
- imem_addr  out  ADDR_WIDTH×FETCH_W  lane i = pc + 4·i.
- imem_valid  in  1  response valid; responses arrive in request order.
- imem_rdata  in  INSTR_WIDTH×FETCH_W  response instructions.
- imem_pc  in  ADDR_WIDTH×FETCH_W  PCs echoed by memory.
- if_valid  out  FETCH_W  per-lane valid of the head group.
- if_pc  out  ADDR_WIDTH×FETCH_W  head group PCs.
- if_instr  out  INSTR_WIDTH×FETCH_W  head group instructions.
- fetch_err  out  1  sticky PC-mismatch flag (see Configuration).

## Operation
- State:
  - pc register.
  - Queue: head/tail pointers, count 0..QDEPTH.
  - inflight counter, 0..MAX_OUTSTANDING.
  - drop_cnt counter, 0..MAX_OUTSTANDING.
- Request: imem_ren = fetch_en & ~redirect_en & (inflight < MAX_OUTSTANDING) & (count + inflight < QDEPTH).
  - imem_addr is driven from the registered pc.
  - When imem_ren=1, pc <= pc + 4·FETCH_W.
- Credit rule: queue space is reserved for every in-flight request, so the queue never overflows and imem_valid is never back-pressured.
- inflight update: +1 on request, −1 on response. Both in the same cycle leaves it unchanged.
- Response: when imem_valid=1 and drop_cnt=0, enqueue the group {imem_pc, imem_rdata}. When imem_valid=1 and drop_cnt>0, discard the group and decrement drop_cnt.
- Output: if_valid = {FETCH_W{count≠0}}; if_pc and if_instr come from the head entry. The head is dequeued when count≠0 & ~stall.
- Redirect (cycle N edge):
  - Queue flushed (count <= 0).
  - pc <= redirect_pc.
  - drop_cnt <= inflight minus any response consumed in cycle N.
  - A response arriving in cycle N is discarded.
  - redirect_en overrides stall and fetch_en.
- Simultaneous enqueue and dequeue: count is unchanged, and a full queue stays legal.
- Pointers wrap modulo QDEPTH. PC arithmetic wraps modulo 2^ADDR_WIDTH.
- Unaligned redirect_pc is legal; lanes are simply consecutive words.

## Timing
- Reset values:
  - imem_ren=0, if_valid=0, if_pc=0, if_instr=0, fetch_err=0.
  - count=inflight=drop_cnt=0, pc=RESET_PC.
- First request occurs in the first cycle with reset=1 and fetch_en=1.
- imem_valid at edge E gives if_valid=1 from E+1 onward; there is no bypass.
- stall=1: the output group is held stable and requests continue until credits are exhausted.
- Redirect asserted in cycle N:
  - imem_ren=0 in cycle N.
  - First request to redirect_pc in cycle N+1.
  - if_valid=0 from N+1 until the first non-dropped response is enqueued.
- Reset asserted mid-operation: all state is cleared at the next edge, and in-flight responses arriving after reset are ignored.

## Configuration
- FETCH_PC_CHECK_EN defined: each non-dropped response compares imem_pc[0] against an expected-PC register.
  - The expected-PC register is advanced by 4·FETCH_W per accepted response and reloaded on redirect.
  - On mismatch, the group is discarded and fetch_err is set until reset.
- FETCH_PC_CHECK_EN undefined: no comparison is made, all non-dropped responses are enqueued, and fetch_err is tied to 0.

## Test plan
- Reset sequence: reset=0 for 2 cycles, then fetch_en=1, with a 2-cycle-latency imem holding 0x11111111.. at word 0. Required response:
  - imem_addr = {0x00,0x04}, then {0x08,0x0C}.
  - First output group PC {0x00,0x04}, instructions {0x11111111,0x22222222}.
- Stall: stall=1 for 1 cycle while the output group is {0x08,0x0C}. Required response: the output is held for 2 cycles, then {0x10,0x14}, with no group lost or duplicated.
- Redirect: redirect_en=1, redirect_pc=0x08 with 2 requests in flight. Required response:
  - imem_ren=0 that cycle and drop_cnt=2.
  - Both stale groups are discarded.
  - The next if_pc is {0x08,0x0C}.
- Back-pressure: stall=1 for 10 cycles with QDEPTH=4. Required response:
  - imem_ren drops once count+inflight=4.
  - count saturates at 4 with no overwrite.
  - After release, groups drain in order 0x00, 0x08, 0x10, 0x18.
- Width sweep: FETCH_W=4, MAX_OUTSTANDING=3. Required response: imem_addr = {0x00,0x04,0x08,0x0C}, then {0x10,..}, with all 4 if_valid lanes set together.
- PC check (FETCH_PC_CHECK_EN defined): the bench returns imem_pc[0]=0x40 when 0x08 is expected. Required response: that group is dropped, fetch_err=1 on the next cycle, and fetch_err stays 1 until reset.
